// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state encoding and iteration count for the multiply/divide controller.
// MULDIV_SIGNED_EN enables the signed DIV opcode and its FIX state.
package muldiv_pkg;

    localparam logic [5:0] OP_MULTU = 6'h13;
    localparam logic [5:0] OP_DIVU  = 6'h14;
    localparam logic [5:0] OP_DIV   = 6'h15;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
`ifdef MULDIV_SIGNED_EN
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam bit         SIGNED_EN = 1'b1;
`else
    localparam bit         SIGNED_EN = 1'b0;
`endif
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int DIV_CYCLES = 32;

    function automatic logic op_valid(input logic [5:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU) || (SIGNED_EN && (op == OP_DIV));
    endfunction

endpackage

// File: rtl/divu_core.sv
// Restoring radix-2 unsigned divider datapath: one quotient bit per step, MSB first.
// The result ports show the post-step value while stepping so the last step can be captured directly.
module divu_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] rem,
    output logic [31:0] quot,
    output logic        last
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] div_q, div_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_step;
    logic [31:0] quot_step;

    always_comb begin
        shifted   = {rem_q, quot_q[31]};
        diff      = shifted - {1'b0, div_q};
        // A borrow out of bit 32 means the trial subtraction failed: restore.
        rem_step  = diff[32] ? shifted[31:0] : diff[31:0];
        quot_step = {quot_q[30:0], ~diff[32]};
    end

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        rem_d  = rem_q;
        quot_d = quot_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        if (load) begin
            rem_d  = '0;
            quot_d = dividend;
            div_d  = divisor;
            cnt_d  = '0;
        end else if (step) begin
            rem_d  = rem_step;
            quot_d = quot_step;
            cnt_d  = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rem  = step ? rem_step : rem_q;
    assign quot = step ? quot_step : quot_q;
    assign last = (cnt_q == 5'(DIV_CYCLES - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULTU/DIVU/DIV controller producing HI/LO; hi/lo only change on entry to DONE.
// MULDIV_SIGNED_EN adds signed DIV (magnitude division plus a one-cycle FIX sign correction).
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  ctrl,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    logic [2:0]  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] product;
    logic [31:0] a_mag, b_mag;
    logic [31:0] core_rem, core_quot;
    logic        core_load, core_step, core_last;

    assign product = {32'd0, a_q} * {32'd0, b_q};

`ifdef MULDIV_SIGNED_EN
    logic [5:0] ctrl_q, ctrl_d;
    logic       signed_op;

    assign signed_op = (ctrl == OP_DIV);
    assign a_mag     = (signed_op && a[31]) ? -a : a;
    assign b_mag     = (signed_op && b[31]) ? -b : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    assign core_step = (state_q == S_DIV);

    divu_core u_divu_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .rem      (core_rem),
        .quot     (core_quot),
        .last     (core_last)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        core_load = 1'b0;
`ifdef MULDIV_SIGNED_EN
        ctrl_d    = ctrl_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && op_valid(ctrl)) begin
                    a_d = a;
                    b_d = b;
`ifdef MULDIV_SIGNED_EN
                    ctrl_d = ctrl;
`endif
                    if (ctrl == OP_MULTU) begin
                        state_d = S_MUL;
                    end else if (b == '0) begin
                        state_d = S_DONE;
                        hi_d    = a;
                        lo_d    = '1;
                    end else begin
                        state_d   = S_DIV;
                        core_load = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = product;
                end
            end
            S_DIV: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (core_last) begin
`ifdef MULDIV_SIGNED_EN
                    if (ctrl_q == OP_DIV) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DONE;
                        hi_d    = core_rem;
                        lo_d    = core_quot;
                    end
`else
                    state_d = S_DONE;
                    hi_d    = core_rem;
                    lo_d    = core_quot;
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            S_FIX: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    lo_d    = (a_q[31] ^ b_q[31]) ? -core_quot : core_quot;
                    hi_d    = a_q[31] ? -core_rem : core_rem;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
            ctrl_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_SIGNED_EN
            ctrl_q  <= ctrl_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model compared every cycle plus directed literal checks.
// Honours MULDIV_SIGNED_EN the same way as the design.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  ctrl = '0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int failures = 0;

`ifdef MULDIV_SIGNED_EN
    localparam bit TB_SIGNED = 1'b1;
`else
    localparam bit TB_SIGNED = 1'b0;
`endif

    muldiv_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (ctrl),
        .start (start),
        .a     (a),
        .b     (b),
        .abort (abort),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: result and cycles-until-done derived from plain arithmetic.
    typedef struct packed {
        logic [7:0]  lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } model_t;

    function automatic logic op_ok(input logic [5:0] c);
        return (c == 6'h13) || (c == 6'h14) || (TB_SIGNED && (c == 6'h15));
    endfunction

    function automatic model_t model_op(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y);
        model_t r;
        logic [63:0] p;
        longint sx, sy, q, m;
        r = '0;
        if (c == 6'h13) begin
            p    = 64'(x) * 64'(y);
            r.hi = p[63:32];
            r.lo = p[31:0];
            r.lat = 8'd2;
        end else if (y == 0) begin
            r.hi = x;
            r.lo = 32'hFFFF_FFFF;
            r.lat = 8'd1;
        end else if (c == 6'h14) begin
            r.lo = x / y;
            r.hi = x % y;
            r.lat = 8'd33;
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = sx / sy;
            m  = sx % sy;
            r.lo = q[31:0];
            r.hi = m[31:0];
            r.lat = 8'd34;
        end
        return r;
    endfunction

    model_t nx;
    always_comb nx = model_op(ctrl, a, b);

    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (m_left == 1) begin
            m_left <= 0;
        end else if (m_left > 1) begin
            if (abort) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 2) begin
                    m_hi <= r_hi;
                    m_lo <= r_lo;
                end
            end
        end else if (start && op_ok(ctrl)) begin
            m_left <= int'(nx.lat);
            r_hi   <= nx.hi;
            r_lo   <= nx.lo;
            if (nx.lat == 8'd1) begin
                m_hi <= nx.hi;
                m_lo <= nx.lo;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", 64'(busy), 64'(m_left != 0));
        check("cyc_done", 64'(done), 64'(m_left == 1));
        check("cyc_hi", 64'(hi), 64'(m_hi));
        check("cyc_lo", 64'(lo), 64'(m_lo));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and measure the cycle distance to done.
    task automatic do_op(input string name, input logic [5:0] c, input logic [31:0] av, input logic [31:0] bv,
                         input logic ab, input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        ctrl  = c;
        a     = av;
        b     = bv;
        start = 1'b1;
        abort = ab;
        step();
        start = 1'b0;
        abort = 1'b0;
        ctrl  = 6'h00;
        lat   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_hi"}, 64'(hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(lo), 64'(exp_lo));
        step();
    endtask

    initial begin
        int n_done;
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        do_op("multu_max", 6'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2, 32'hFFFF_FFFE, 32'h0000_0001);
        check("model_pin_lo", 64'(m_lo), 64'h1);
        do_op("divu_100_7", 6'h14, 32'd100, 32'd7, 1'b0, 33, 32'd2, 32'd14);
        do_op("divu_by0", 6'h14, 32'd5, 32'd0, 1'b0, 1, 32'd5, 32'hFFFF_FFFF);
        do_op("divu_max_1", 6'h14, 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32'd0, 32'hFFFF_FFFF);
        do_op("divu_hex", 6'h14, 32'h1234_5678, 32'h100, 1'b0, 33, 32'h78, 32'h0012_3456);
        do_op("divu_small", 6'h14, 32'd3, 32'd10, 1'b0, 33, 32'd3, 32'd0);
        check("model_pin_hi", 64'(m_hi), 64'd3);
        do_op("multu_ab_start", 6'h13, 32'h0001_0000, 32'h0001_0000, 1'b1, 2, 32'h1, 32'h0);

`ifdef MULDIV_SIGNED_EN
        do_op("div_neg", 6'h15, 32'hFFFF_FF9C, 32'd7, 1'b0, 34, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        do_op("div_ovf", 6'h15, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 34, 32'h0, 32'h8000_0000);
        do_op("div_negb", 6'h15, 32'd100, 32'hFFFF_FFF9, 1'b0, 34, 32'd2, 32'hFFFF_FFF2);
        do_op("div_by0", 6'h15, 32'd7, 32'd0, 1'b0, 1, 32'd7, 32'hFFFF_FFFF);
`else
        ctrl = 6'h15; a = 32'd9; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        check("div_disabled_busy", 64'(busy), 64'd0);
        step();
`endif
        ctrl = 6'h00; start = 1'b1;
        step();
        start = 1'b0;
        check("nop_busy", 64'(busy), 64'd0);
        step();

        // Abort during DIV; a stray start mid-operation must be ignored.
        do_op("multu_3_5", 6'h13, 32'd3, 32'd5, 1'b0, 2, 32'd0, 32'd15);
        ctrl = 6'h14; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        ctrl = 6'h13; a = 32'd3; b = 32'd4; start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_div_busy", 64'(busy), 64'd0);
        check("abort_div_lo", 64'(lo), 64'd15);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_div_nodone", 64'(n_done), 64'd0);
        step();

        ctrl = 6'h13; a = 32'd7; b = 32'd9; start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_mul_busy", 64'(busy), 64'd0);
        check("abort_mul_lo", 64'(lo), 64'd15);
        step();

        // Asynchronous reset in the middle of a division.
        ctrl = 6'h14; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();
        do_op("multu_3_4", 6'h13, 32'd3, 32'd4, 1'b0, 2, 32'd0, 32'd12);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
